proc_trace_buffer: RTL

PROC_TRACE_BUFFER -- requirements
Module: proc_trace_buffer

---
 rtl/proc_trace_buffer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/proc_trace_buffer.sv
// proc_trace_buffer
// Circular instruction-retire trace buffer with a PC breakpoint trigger.
// After `arm` every retired instruction is recorded. When the breakpoint PC
// retires, `post_cnt` further entries are captured, then the block stops
// (`halt`) and the stored entries can be drained oldest-first through a
// valid/ready read port.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   cap_valid/pc/instr         retiring instruction
//   cap_we/waddr/wdata         its register write-back
//   arm                        clear the buffer and start capturing
//   bp_en, bp_pc               breakpoint enable and PC
//   post_cnt                   entries to capture after the trigger entry
//   rd_ready                   reader accepts rd_data
//   rd_valid, rd_data          oldest unread entry {pc, instr, we, waddr, wdata}
//   halt                       capture complete (registered)
//   state                      IDLE=00, ARMED=01, POST=10, DONE=11
//   count                      valid, unread entries
//   overflow                   older entries were overwritten
module proc_trace_buffer #(
  parameter int PC_W    = 16,
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int DEPTH   = 8,
  localparam int CW     = $clog2(DEPTH),
  localparam int EW     = PC_W + 17 + RADDR_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cap_valid,
  input  logic [PC_W-1:0]    cap_pc,
  input  logic [15:0]        cap_instr,
  input  logic               cap_we,
  input  logic [RADDR_W-1:0] cap_waddr,
  input  logic [DATA_W-1:0]  cap_wdata,
  input  logic               arm,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_pc,
  input  logic [CW-1:0]      post_cnt,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [EW-1:0]      rd_data,
  output logic               halt,
  output logic [1:0]         state,
  output logic [CW:0]        count,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    POST  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

  state_t          state_q;
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   remaining;
  logic [CW-1:0]   rd_ptr;
  logic [EW-1:0]   mem [DEPTH];
  logic            capturing;
  logic            write_en;
  logic            trigger;
  logic            rd_fire;

  assign state     = state_q;
  assign capturing = (state_q == ARMED) || (state_q == POST);
  // A capture coinciding with arm is dropped: arm restarts the buffer.
  assign write_en  = cap_valid && capturing && !arm;
  assign trigger   = write_en && (state_q == ARMED) && bp_en && (cap_pc == bp_pc);
  assign rd_valid  = (state_q == DONE) && (count != '0);
  assign rd_fire   = rd_valid && rd_ready;

  // Oldest unread entry sits `count` slots behind the write pointer. With
  // count == DEPTH the low bits are zero, which lands on wr_ptr itself: the
  // oldest surviving entry after a wrap.
  assign rd_ptr    = wr_ptr - count[CW-1:0];
  assign rd_data   = mem[rd_ptr];

  // NOTE: the trace RAM has no reset; its contents are meaningless until
  // written, and count/rd_valid keep stale slots from ever being read.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr] <= {cap_pc, cap_instr, cap_we, cap_waddr, cap_wdata};
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      halt      <= 1'b0;
    end else if (arm) begin
      state_q   <= ARMED;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      halt      <= 1'b0;
    end else begin
      // Writes only happen while capturing and reads only in DONE, so the
      // two count updates never coincide.
      if (write_en) begin
        wr_ptr <= wr_ptr + CW'(1);
        if (count == FULL) begin
          overflow <= 1'b1;
        end else begin
          count <= count + (CW+1)'(1);
        end
      end else if (rd_fire) begin
        count <= count - (CW+1)'(1);
      end

      case (state_q)
        ARMED: begin
          if (trigger) begin
            if (post_cnt == '0) begin
              state_q <= DONE;
              halt    <= 1'b1;
            end else begin
              state_q   <= POST;
              remaining <= post_cnt;
            end
          end
        end
        POST: begin
          if (write_en) begin
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              state_q <= DONE;
              halt    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
